// File: rtl/mac_job_sched.sv
// mac_job_sched
//   Collects MAC jobs from several cores and runs them one at a time on a
//   single MAC engine. Admission uses round-robin arbitration into a small
//   FIFO. A five-state sequencer clears the engine, starts it, waits for
//   completion and then raises a completion event to the core that owns the
//   job.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   job_valid_i  : [N_CORES]            per-core job request
//   job_ready_o  : [N_CORES]            per-core accept (one-hot or zero)
//   job_len_i    : [N_CORES][LEN_WIDTH] per-core job length (MAC operations)
//   job_mul_i    : [N_CORES]            per-core simple-multiply mode flag
//   eng_clear_o  : one-cycle engine/streamer clear
//   eng_start_o  : one-cycle engine start (suppressed for zero-length jobs)
//   eng_len_o    : active job length, stable from CLEAR through RUN
//   eng_mul_o    : active job mode flag, stable from CLEAR through RUN
//   eng_done_i   : engine completion pulse, only honoured in RUN
//   evt_o        : [N_CORES] one-cycle completion event to the owning core
//   busy_o       : sequencer not idle
//   pending_o    : queue occupancy
//
// Sequencer states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no active job; pops the queue head when one is available
//   S_CLEAR | active job loaded; engine clear pulse
//   S_START | engine start pulse, skipped for zero-length jobs
//   S_RUN   | engine running; waits for eng_done_i
//   S_EVT   | completion event to the owning core
module mac_job_sched #(
  parameter int N_CORES   = 2,
  parameter int DEPTH     = 4,
  parameter int LEN_WIDTH = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_CORES-1:0]                  job_valid_i,
  output logic [N_CORES-1:0]                  job_ready_o,
  input  logic [N_CORES-1:0][LEN_WIDTH-1:0]   job_len_i,
  input  logic [N_CORES-1:0]                  job_mul_i,
  output logic                                eng_clear_o,
  output logic                                eng_start_o,
  output logic [LEN_WIDTH-1:0]                eng_len_o,
  output logic                                eng_mul_o,
  input  logic                                eng_done_i,
  output logic [N_CORES-1:0]                  evt_o,
  output logic                                busy_o,
  output logic [$clog2(DEPTH):0]              pending_o
);

  localparam int CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_RUN,
    S_EVT
  } state_t;

  state_t state_q, state_d;

  // Round-robin admission
  logic [CORE_W-1:0] rr_ptr;
  logic [CORE_W-1:0] gnt_idx;
  logic              gnt_found;
  int                cand;

  // Job queue
  logic [CORE_W-1:0]    q_core [DEPTH];
  logic [LEN_WIDTH-1:0] q_len  [DEPTH];
  logic                 q_mul  [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // Active job
  logic [CORE_W-1:0]    act_core;
  logic [LEN_WIDTH-1:0] act_len;
  logic                 act_mul;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // The head is popped only from IDLE, so the pop is known combinationally
  // and lets a push into a full queue go through in the same cycle.
  assign pop  = (state_q == S_IDLE) && !empty;
  assign push = gnt_found && (!full || pop);

  // Search starts at rr_ptr and wraps; the first requesting core wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N_CORES; i++) begin
      cand = (int'(rr_ptr) + i) % N_CORES;
      if (!gnt_found && job_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = CORE_W'(cand);
      end
    end
  end

  always_comb begin
    job_ready_o = '0;
    if (push) begin
      job_ready_o = N_CORES'(1) << gnt_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= CORE_W'((int'(gnt_idx) + 1) % N_CORES);
    end
  end

  // Queue storage needs no reset; only the pointers and count define content.
  always_ff @(posedge clk_i) begin
    if (push) begin
      q_core[wr_ptr] <= gnt_idx;
      q_len[wr_ptr]  <= job_len_i[gnt_idx];
      q_mul[wr_ptr]  <= job_mul_i[gnt_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign pending_o = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      act_core <= '0;
      act_len  <= '0;
      act_mul  <= 1'b0;
    end else if (pop) begin
      act_core <= q_core[rd_ptr];
      act_len  <= q_len[rd_ptr];
      act_mul  <= q_mul[rd_ptr];
    end
  end

  assign eng_len_o = act_len;
  assign eng_mul_o = act_mul;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    eng_clear_o = 1'b0;
    eng_start_o = 1'b0;
    evt_o       = '0;
    busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        eng_clear_o = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        // A zero-length job never touches the engine and completes at once.
        if (act_len != '0) begin
          eng_start_o = 1'b1;
          state_d     = S_RUN;
        end else begin
          state_d = S_EVT;
        end
      end
      S_RUN: begin
        if (eng_done_i) begin
          state_d = S_EVT;
        end
      end
      S_EVT: begin
        evt_o   = N_CORES'(1) << act_core;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
